// File: rtl/lcd_stream_pkg.sv
// lcd_stream_pkg
// Shared types and constants for the 8080-style LCD streaming controller.
//   lcd_state_t  : controller FSM states
//   wr_phase_t   : byte-write strobe phases
//   MEMWR_CMD_DEFAULT : memory-write command that opens each frame
//   RGB_*_W      : RGB565 field widths used to build test-pattern pixels
package lcd_stream_pkg;

  typedef enum logic [2:0] {
    INIT_IDLE,
    INIT_WRITE,
    INIT_RELEASE,
    FRAME_WAIT,
    FRAME_CMD,
    PIXELS
  } lcd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_LOW,
    WR_HIGH
  } wr_phase_t;

  localparam logic [7:0] MEMWR_CMD_DEFAULT = 8'h2C;

  localparam int RGB_R_W  = 5;
  localparam int RGB_G_W  = 6;
  localparam int RGB_B_W  = 5;
  localparam int RGB565_W = RGB_R_W + RGB_G_W + RGB_B_W;

endpackage

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer
// One 8080-style byte write: rs/data are registered together with the falling
// edge of the strobe, wr stays low WR_LOW_CYC cycles, then high WR_HIGH_CYC
// cycles. rs/data hold their value until the next accepted write.
// Ports:
//   fancy_clk, rst        : clock, async active-high reset
//   start, rs_next,
//   data_next             : request a write (accepted only when busy=0)
//   busy                  : a write is in progress and cannot accept start
//   done                  : last cycle of the high phase (write completes)
//   lcd_wr, lcd_rs,
//   lcd_data              : LCD bus pins
module lcd_bus_writer
  import lcd_stream_pkg::*;
#(
  parameter int WR_LOW_CYC  = 2,
  parameter int WR_HIGH_CYC = 2
) (
  input  logic       fancy_clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs_next,
  input  logic [7:0] data_next,
  output logic       busy,
  output logic       done,
  output logic       lcd_wr,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int MAXC = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  wr_phase_t       phase;
  logic [CW-1:0]   cnt;

  assign done = (phase == WR_HIGH) && (cnt == '0);
  // The final high cycle can already accept the next byte, giving
  // back-to-back writes with no idle gap.
  assign busy = (phase != WR_IDLE) && !done;

  always_ff @(posedge fancy_clk or posedge rst) begin
    if (rst) begin
      phase    <= WR_IDLE;
      cnt      <= '0;
      lcd_wr   <= 1'b1;
      lcd_rs   <= 1'b0;
      lcd_data <= 8'h00;
    end else if (start && !busy) begin
      phase    <= WR_LOW;
      cnt      <= CW'(WR_LOW_CYC - 1);
      lcd_wr   <= 1'b0;
      lcd_rs   <= rs_next;
      lcd_data <= data_next;
    end else begin
      case (phase)
        WR_LOW: begin
          if (cnt == '0) begin
            phase  <= WR_HIGH;
            cnt    <= CW'(WR_HIGH_CYC - 1);
            lcd_wr <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WR_HIGH: begin
          if (cnt == '0) phase <= WR_IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: phase <= WR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_stream_ctrl.sv
// lcd_stream_ctrl
// Replays an init sequence received over a 4-phase handshake, then streams an
// RGB565 test pattern to an 8080-style LCD, one MEMWR command per frame.
// Optional build macro LCD_FMARK_SYNC_EN: when defined, each frame waits for a
// rising edge of the synchronized LCD frame mark; otherwise frames run
// back-to-back and i_lcd_fmark is unused.
// Ports:
//   i_clk, i_reset        : clock, async active-high reset
//   i_lcd_fmark           : LCD tearing/frame mark (async)
//   o_lcd_wr/rs/data      : LCD bus
//   i_init_rom            : init word {rs, byte}
//   i_init_rdy, i_init_done (async), o_init_ack : init handshake
//
// state        | meaning
// INIT_IDLE    | waiting for an init word or end-of-init
// INIT_WRITE   | init byte on the bus, ack high
// INIT_RELEASE | ack high until producer drops rdy
// FRAME_WAIT   | waiting for frame trigger
// FRAME_CMD    | issuing MEMWR_CMD (rs=0)
// PIXELS       | streaming pixel bytes, high byte first
module lcd_stream_ctrl
  import lcd_stream_pkg::*;
#(
  parameter int         WR_LOW_CYC  = 2,
  parameter int         WR_HIGH_CYC = 2,
  parameter int         H_RES       = 320,
  parameter int         V_RES       = 240,
  parameter logic [7:0] MEMWR_CMD   = MEMWR_CMD_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_lcd_fmark,
  output logic       o_lcd_wr,
  output logic       o_lcd_rs,
  output logic [7:0] o_lcd_data,
  input  logic [8:0] i_init_rom,
  input  logic       i_init_rdy,
  input  logic       i_init_done,
  output logic       o_init_ack
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  lcd_state_t            state;
  logic [1:0]            rdy_sync, done_sync;
  logic                  rdy_s, done_s;
  logic [XW-1:0]         x_cnt;
  logic [YW-1:0]         y_cnt;
  logic [7:0]            frame_cnt;
  logic                  byte_hi;
  logic [RGB565_W-1:0]   pixel;
  logic                  frame_trig;

  logic                  wr_start, wr_rs, wr_busy, wr_done;
  logic [7:0]            wr_data;

  assign rdy_s  = rdy_sync[1];
  assign done_s = done_sync[1];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rdy_sync  <= 2'b00;
      done_sync <= 2'b00;
    end else begin
      rdy_sync  <= {rdy_sync[0], i_init_rdy};
      done_sync <= {done_sync[0], i_init_done};
    end
  end

`ifdef LCD_FMARK_SYNC_EN
  logic [1:0] fmark_sync;
  logic       fmark_prev;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fmark_sync <= 2'b00;
      fmark_prev <= 1'b0;
    end else begin
      fmark_sync <= {fmark_sync[0], i_lcd_fmark};
      fmark_prev <= fmark_sync[1];
    end
  end

  // Edge history runs continuously, so an edge seen mid-frame is consumed
  // and never queued for the next FRAME_WAIT.
  assign frame_trig = fmark_sync[1] && !fmark_prev;
`else
  logic unused_fmark;
  assign unused_fmark = i_lcd_fmark;
  assign frame_trig   = 1'b1;
`endif

  assign pixel = {RGB_R_W'(x_cnt >> 3), RGB_G_W'(y_cnt >> 2), RGB_B_W'(frame_cnt)};

  // Write requests are decoded from state so rs/data, the strobe and the
  // init ack all change on the same clock edge.
  always_comb begin
    wr_start = 1'b0;
    wr_rs    = 1'b0;
    wr_data  = 8'h00;
    case (state)
      INIT_IDLE: begin
        if (!done_s && rdy_s && !o_init_ack) begin
          wr_start = 1'b1;
          wr_rs    = i_init_rom[8];
          wr_data  = i_init_rom[7:0];
        end
      end
      FRAME_CMD: begin
        wr_start = !wr_busy;
        wr_data  = MEMWR_CMD;
      end
      PIXELS: begin
        wr_start = !wr_busy;
        wr_rs    = 1'b1;
        wr_data  = byte_hi ? pixel[15:8] : pixel[7:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= INIT_IDLE;
      o_init_ack <= 1'b0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      frame_cnt  <= 8'h00;
      byte_hi    <= 1'b1;
    end else begin
      case (state)
        INIT_IDLE: begin
          if (done_s) begin
            state <= FRAME_WAIT;
          end else if (rdy_s && !o_init_ack) begin
            o_init_ack <= 1'b1;
            state      <= INIT_WRITE;
          end
        end
        INIT_WRITE: begin
          if (wr_done) state <= INIT_RELEASE;
        end
        INIT_RELEASE: begin
          if (!rdy_s) begin
            o_init_ack <= 1'b0;
            state      <= INIT_IDLE;
          end
        end
        FRAME_WAIT: begin
          if (frame_trig) state <= FRAME_CMD;
        end
        FRAME_CMD: begin
          if (wr_start) begin
            byte_hi <= 1'b1;
            state   <= PIXELS;
          end
        end
        PIXELS: begin
          if (wr_start) begin
            if (byte_hi) begin
              byte_hi <= 1'b0;
            end else begin
              byte_hi <= 1'b1;
              if (x_cnt == XW'(H_RES - 1)) begin
                x_cnt <= '0;
                if (y_cnt == YW'(V_RES - 1)) begin
                  y_cnt     <= '0;
                  frame_cnt <= frame_cnt + 8'd1;
                  state     <= FRAME_WAIT;
                end else begin
                  y_cnt <= y_cnt + 1'b1;
                end
              end else begin
                x_cnt <= x_cnt + 1'b1;
              end
            end
          end
        end
        default: state <= INIT_IDLE;
      endcase
    end
  end

  lcd_bus_writer #(
    .WR_LOW_CYC (WR_LOW_CYC),
    .WR_HIGH_CYC(WR_HIGH_CYC)
  ) u_bus_writer (
    .fancy_clk(i_clk),
    .rst      (i_reset),
    .start    (wr_start),
    .rs_next  (wr_rs),
    .data_next(wr_data),
    .busy     (wr_busy),
    .done     (wr_done),
    .lcd_wr   (o_lcd_wr),
    .lcd_rs   (o_lcd_rs),
    .lcd_data (o_lcd_data)
  );

endmodule

// File: tb/tb_lcd_stream_ctrl.sv
// tb_lcd_stream_ctrl
// Scoreboard bench for lcd_stream_ctrl with a reduced 16x8 frame. Expected
// bus bytes {rs, data} are queued by the stimulus and popped by a monitor on
// each rising edge of the write strobe. Build with LCD_FMARK_SYNC_EN to
// exercise the frame-mark gated variant.
module tb_lcd_stream_ctrl;

  localparam int H  = 16;
  localparam int V  = 8;
  localparam int WL = 2;
  localparam int WH = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fmark = 1'b0;
  logic       rdy = 1'b0;
  logic       done = 1'b0;
  logic [8:0] rom = 9'h000;
  logic       lcd_wr, lcd_rs, ack;
  logic [7:0] lcd_data;

  lcd_stream_ctrl #(
    .WR_LOW_CYC (WL),
    .WR_HIGH_CYC(WH),
    .H_RES      (H),
    .V_RES      (V),
    .MEMWR_CMD  (8'h2C)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_lcd_fmark(fmark),
    .o_lcd_wr   (lcd_wr),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_data (lcd_data),
    .i_init_rom (rom),
    .i_init_rdy (rdy),
    .i_init_done(done),
    .o_init_ack (ack)
  );

  always #10 clk = ~clk;

  int         n_checks = 0;
  int         n_pass = 0;
  logic [8:0] exp_q[$];
  logic [8:0] log_q[$];
  bit         mon_en = 1'b0;
  int         low_cnt = 0;
  bit         prev_low = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Strobe low-width measurement, sampled away from the active edge.
  always @(negedge clk) begin
    if (lcd_wr === 1'b0) low_cnt = prev_low ? low_cnt + 1 : 1;
    prev_low = (lcd_wr === 1'b0);
  end

  always @(posedge lcd_wr) begin
    if (!rst && mon_en) begin
      log_q.push_back({lcd_rs, lcd_data});
      check("wr_low_width", low_cnt, WL);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_byte: got rs=%0d data=0x%02h expected none at %0t",
                 lcd_rs, lcd_data, $time);
      end else begin
        check("bus_byte", {lcd_rs, lcd_data}, exp_q.pop_front());
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input logic v, input int maxc, input string name);
    int i = 0;
    while (ack !== v && i < maxc) begin
      @(negedge clk);
      i++;
    end
    check(name, ack, v);
  endtask

  task automatic wait_wr_low(input int maxc, input string name);
    int i = 0;
    while (lcd_wr !== 1'b0 && i < maxc) begin
      @(negedge clk);
      i++;
    end
    check(name, lcd_wr, 1'b0);
  endtask

  task automatic wait_drain(input int maxc, input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < maxc) begin
      @(negedge clk);
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic push_frame(input logic [7:0] f);
    logic [15:0] p;
    logic [7:0]  xb, yb;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        xb = 8'(x);
        yb = 8'(y);
        p  = {xb[7:3], yb[7:2], f[4:0]};
        exp_q.push_back({1'b1, p[15:8]});
        exp_q.push_back({1'b1, p[7:0]});
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
  endtask

`ifdef LCD_FMARK_SYNC_EN
  task automatic pulse_fmark();
    fmark = 1'b1;
    cycles(4);
    fmark = 1'b0;
  endtask
`endif

  initial begin
    int n_rs1;
    logic [8:0] slow_words[2];
    slow_words[0] = 9'h1A5;
    slow_words[1] = 9'h029;

    #1 rst = 1'b1;
    #1;
    check("rst_wr", lcd_wr, 1'b1);
    check("rst_rs", lcd_rs, 1'b0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_ack", ack, 1'b0);
    cycles(3);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single word with rdy held high: one byte, ack held until rdy drops.
    rom = 9'h011;
    exp_q.push_back(9'h011);
    rdy = 1'b1;
    wait_ack(1'b1, 10, "ack_rise_single");
    cycles(40);
    check("ack_hold_single", ack, 1'b1);
    check("single_byte_seen", exp_q.size(), 0);
    rdy = 1'b0;
    wait_ack(1'b0, 10, "ack_fall_single");
    cycles(10);

    // Asynchronous reset in the middle of a write.
    rom = 9'h155;
    rdy = 1'b1;
    wait_wr_low(10, "mid_write_started");
    #3 rst = 1'b1;
    #1;
    check("midrst_wr", lcd_wr, 1'b1);
    check("midrst_rs", lcd_rs, 1'b0);
    check("midrst_data", lcd_data, 8'h00);
    check("midrst_ack", ack, 1'b0);
    rdy = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(5);

    // Slow producer toggling rdy every microsecond.
    foreach (slow_words[k]) begin
      exp_q.push_back(slow_words[k]);
      rom = slow_words[k];
      rdy = 1'b1;
      #1000;
      check("slow_ack_high", ack, 1'b1);
      rdy = 1'b0;
      #1000;
      check("slow_ack_low", ack, 1'b0);
    end
    wait_drain(10, "slow_drain");

    // End-of-init while an init write is in flight.
    @(negedge clk);
    rom = 9'h03A;
    exp_q.push_back(9'h03A);
    rdy = 1'b1;
    wait_wr_low(10, "inflight_started");
    done = 1'b1;
    cycles(30);
    check("inflight_byte_seen", exp_q.size(), 0);
    check("ack_held_with_done", ack, 1'b1);
    exp_q.push_back(9'h02C);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h100);
    rdy = 1'b0;
    wait_ack(1'b0, 10, "ack_release_with_done");
    wait_drain(100, "cmd_after_done");
    mon_en = 1'b0;
    rom = 9'h077;
    rdy = 1'b1;
    cycles(20);
    check("no_ack_after_init", ack, 1'b0);
    rdy = 1'b0;

    // Pattern streaming from a clean start with done and rdy=0.
    done = 1'b0;
    pulse_reset();
    exp_q.delete();
    log_q.delete();
    mon_en = 1'b1;
    done = 1'b1;
`ifdef LCD_FMARK_SYNC_EN
    cycles(100);
    check("no_bytes_before_fmark", log_q.size(), 0);
    exp_q.push_back(9'h02C);
    push_frame(8'd0);
    pulse_fmark();
    begin
      int i = 0;
      while (log_q.size() < 100 && i < 2000) begin
        @(negedge clk);
        i++;
      end
    end
    pulse_fmark();
    wait_drain(4000, "frame0_drain");
    cycles(100);
    check("no_restart_mid_frame", log_q.size(), 257);
    exp_q.push_back(9'h02C);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h101);
    pulse_fmark();
    wait_drain(500, "frame1_after_fmark");
`else
    exp_q.push_back(9'h02C);
    push_frame(8'd0);
    exp_q.push_back(9'h02C);
    exp_q.push_back(9'h100);
    exp_q.push_back(9'h101);
    wait_drain(4000, "frame_drain");
`endif
    mon_en = 1'b0;

    check("log_len", log_q.size(), 260);
    if (log_q.size() >= 260) begin
      check("f0_cmd", log_q[0], 9'h02C);
      check("f0_px0_hi", log_q[1], 9'h100);
      check("f0_px0_lo", log_q[2], 9'h100);
      check("px_x8_y4", {log_q[145][7:0], log_q[146][7:0]}, 16'h0820);
      n_rs1 = 0;
      for (int i = 1; i <= 256; i++) if (log_q[i][8]) n_rs1++;
      check("f0_rs1_count", n_rs1, 2 * H * V);
      check("f1_cmd", log_q[257], 9'h02C);
      check("f1_px0_lo_blue", log_q[259], 9'h101);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
